div_clk_monitor: RTL and testbench
==================================

# div_clk_monitor

Checks the divided clock-enable waveform produced by the divide-by-3 stage, sampled in the same `clk` domain. Detects rising edges, measures period and high time in `clk` cycles, and declares lock after a run of periods matching the expected values. Flags mismatches and loss-of-edge timeouts to the system status logic through a pulsed error and a saturating error counter.

## Interface
Parameters:
- `CNT_W`, 8: width of the period and high-time counters.
- `EXP_PERIOD`, 3: expected period in `clk` cycles; must be ≥ 2.
- `EXP_HIGH`, 1: expected high time in `clk` cycles; used only with the duty check.
- `LOCK_CNT`, 4: number of consecutive matching periods required for lock; must be ≥ 1.
- `TIMEOUT`, 16: cycles without a rising edge before a timeout; must satisfy EXP_PERIOD < TIMEOUT < 2^CNT_W.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `i_en` in 1: monitor enable.
- `i_div_clk` in 1: divided waveform, synchronous to `clk`; no synchroniser.
- `i_err_clr` in 1: synchronous clear of `o_err_cnt`.
- `o_rise` out 1: one-cycle pulse per detected rising edge.
- `o_period` out CNT_W: last measured period.
- `o_high` out CNT_W: last measured high time.
- `o_period_vld` out 1: one-cycle pulse when `o_period`/`o_high` update.
- `o_locked` out 1: level; asserted while in LOCKED.
- `o_err` out 1: one-cycle error pulse.
- `o_err_cnt` out 8: count of error pulses, saturating at 255.

## Operation
- Edge detect: `prev` registers `i_div_clk`; `rise_det = i_div_clk & ~prev`.
- `per_cnt`: loads 1 on `rise_det`, otherwise increments, saturating at 2^CNT_W−1. On `rise_det`, the measured period equals the current `per_cnt`.
- `high_cnt`: loads 1 on `rise_det`, increments while `i_div_clk` is high, holds while it is low. On `rise_det`, the measured high time equals the current `high_cnt`.
- A period matches when period == EXP_PERIOD, plus high == EXP_HIGH when the duty check is compiled in.
- State machine:
  - IDLE: waiting for the first edge. `rise_det` → MEASURE. No period is published on this first edge.
  - MEASURE: on `rise_det`, publish period/high and pulse `o_period_vld`.
    - Match: `match_cnt`++. When it reaches LOCK_CNT → LOCKED.
    - Mismatch: `match_cnt` ← 0, stay in MEASURE, no `o_err`.
  - LOCKED: on `rise_det`, publish.
    - Mismatch: pulse `o_err`, `match_cnt` ← 0, → MEASURE.
  - Timeout, in MEASURE or LOCKED: `per_cnt` == TIMEOUT with no `rise_det` → pulse `o_err`, → IDLE, `match_cnt` ← 0.
- `i_en` low: synchronously → IDLE. Counters, `match_cnt`, and all pulse outputs are zeroed. `o_err_cnt` and the last `o_period`/`o_high` values hold. No errors are raised while disabled.
- `o_err_cnt`: increments on each `o_err` and saturates at 255. If `i_err_clr` and an error coincide, the result is 1 (clear first, then count).
- Reset, including mid-operation: state → IDLE; every output and counter → 0 asynchronously.

## Timing
- `i_div_clk` first sampled high at edge n → `o_rise` high in cycle n+1.
- `o_period`, `o_high`, and `o_period_vld` update in the same cycle as `o_rise`.
- `o_locked` rises in the same cycle as the `o_period_vld` of the LOCK_CNT-th consecutive match.
- `o_locked` falls in the same cycle as the mismatch `o_err`, or the cycle after a timeout.
- Timeout `o_err` is registered: it appears the cycle after `per_cnt` reaches TIMEOUT.
- For the divide-by-3 waveform (high 1, low 2), LOCK_CNT=4 gives `o_locked` at the 5th `o_rise`.

## Configuration
- `DIV_MON_DUTY_CHECK_EN` defined: a high-time mismatch also counts as a mismatch.
- Not defined: `o_high` is still measured and published, but it never affects lock or error.

## Structure
- Package `div_mon_pkg`:
  - state enum typedef (IDLE, MEASURE, LOCKED);
  - error-counter width constant (8);
  - saturation helper constant.
- Sub-module `div_edge_det`: `prev` register plus `rise_det`; clock/reset/enable ports.

## Test plan
- Divide-by-3 waveform, `i_en`=1 → first `o_period_vld` with period=3, high=1; `o_locked`=1 at the 5th `o_rise`; `o_err_cnt` stays 0.
- While locked, stretch one period to 4 → `o_err` pulse with `o_period`=4; `o_locked`=0; `o_err_cnt`=1; relock after 4 further matching periods.
- While locked, hold `i_div_clk` low → `o_err` pulse the cycle after `per_cnt` reaches 16; state IDLE; `o_err_cnt`+1; no period published on the next edge.
- `i_err_clr` in the same cycle as an `o_err` pulse with `o_err_cnt`=5 → `o_err_cnt`=1. Force 260 errors → `o_err_cnt`=255.
- Assert `reset` mid-lock → all outputs 0 immediately. Deassert → the first edge publishes nothing; lock returns after 4 matches.
- Waveform with high=2, period=3 → with `DIV_MON_DUTY_CHECK_EN`, never locks (`o_high`=2 on every `o_period_vld`). Without the macro, locks at the 5th `o_rise`.

Source files
------------

// File: rtl/div_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_mon_pkg
// Description : Shared types and constants for the divided clock-enable
//               monitor: monitor state encoding and error-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package div_mon_pkg;

    // Monitor state: waiting for a first edge, qualifying periods, locked.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } div_mon_state_e;

    // Error counter width and its saturation value.
    localparam int                     c_err_cnt_w   = 8;
    localparam logic [c_err_cnt_w-1:0] c_err_cnt_max = '1;

endpackage : div_mon_pkg
`default_nettype wire

// File: rtl/div_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : div_edge_det
// Description : Rising-edge detector for a waveform already synchronous to
//               clk. Registers the previous sample and flags a 0->1 step.
//               While disabled the history is cleared, so a waveform that is
//               high when the block is re-enabled counts as a fresh edge.
// Ports       : clk     - clock
//               reset   - asynchronous active-high reset
//               i_en    - detector enable
//               i_din   - sampled waveform
//               o_rise  - combinational rising-edge flag
// Revision    : 1.0 - initial release
// ============================================================================
module div_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_din,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else if (!i_en) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_din;
        end
    end

    assign o_rise = i_en & i_din & ~r_prev;

endmodule : div_edge_det
`default_nettype wire

// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module      : div_clk_monitor
// Description : Monitors the divided clock-enable waveform in the clk domain.
//               Measures period and high time between rising edges, declares
//               lock after LOCK_CNT consecutive matching periods, and reports
//               mismatches while locked and loss-of-edge timeouts as a one-cycle
//               error pulse plus a saturating error counter.
//               Compile option: define DIV_MON_DUTY_CHECK_EN to make the high
//               time part of the match criterion.
// Ports       : clk          - clock
//               reset        - asynchronous active-high reset
//               i_en         - monitor enable (low forces IDLE)
//               i_div_clk    - divided waveform, synchronous to clk
//               i_err_clr    - synchronous clear of o_err_cnt
//               o_rise       - pulse per detected rising edge
//               o_period     - last measured period
//               o_high       - last measured high time
//               o_period_vld - pulse when o_period/o_high update
//               o_locked     - level, high while locked
//               o_err        - one-cycle error pulse
//               o_err_cnt    - saturating count of error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 3,
    parameter int EXP_HIGH   = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_en,
    input  logic                   i_div_clk,
    input  logic                   i_err_clr,
    output logic                   o_rise,
    output logic [CNT_W-1:0]       o_period,
    output logic [CNT_W-1:0]       o_high,
    output logic                   o_period_vld,
    output logic                   o_locked,
    output logic                   o_err,
    output logic [c_err_cnt_w-1:0] o_err_cnt
);

    localparam int                   c_match_w    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]     c_cnt_max    = '1;
    localparam logic [CNT_W-1:0]     c_exp_period = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]     c_exp_high   = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0]     c_timeout    = CNT_W'(TIMEOUT);
    localparam logic [c_match_w-1:0] c_lock_last  = c_match_w'(LOCK_CNT - 1);
`ifdef DIV_MON_DUTY_CHECK_EN
    localparam logic                 c_duty_check = 1'b1;
`else
    localparam logic                 c_duty_check = 1'b0;
`endif

    div_mon_state_e         r_state;
    div_mon_state_e         w_state_nxt;
    logic [c_match_w-1:0]   r_match_cnt;
    logic [c_match_w-1:0]   w_match_cnt_nxt;
    logic [CNT_W-1:0]       r_per_cnt;
    logic [CNT_W-1:0]       r_high_cnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic                   r_rise;
    logic                   r_period_vld;
    logic                   r_err;
    logic [c_err_cnt_w-1:0] r_err_cnt;
    logic                   w_rise;
    logic                   w_match;
    logic                   w_timeout;
    logic                   w_publish;
    logic                   w_err;

    div_edge_det u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .i_en   (i_en),
        .i_din  (i_div_clk),
        .o_rise (w_rise)
    );

    // The counters hold the length of the period that is ending on this edge;
    // an edge arriving exactly at the timeout count is a (long) period, not a
    // timeout.
    always_comb begin
        w_match   = (r_per_cnt == c_exp_period) &&
                    (!c_duty_check || (r_high_cnt == c_exp_high));
        w_timeout = !w_rise && (r_per_cnt == c_timeout);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_publish       = 1'b0;
        w_err           = 1'b0;
        case (r_state)
            IDLE: begin
                // First edge only starts the measurement window.
                w_match_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_publish = 1'b1;
                    if (w_match) begin
                        w_match_cnt_nxt = r_match_cnt + c_match_w'(1);
                        if (r_match_cnt == c_lock_last) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_match_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_err           = 1'b1;
                    w_match_cnt_nxt = '0;
                    w_state_nxt     = IDLE;
                end
            end
            LOCKED: begin
                if (w_rise) begin
                    w_publish = 1'b1;
                    if (!w_match) begin
                        w_err           = 1'b1;
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = MEASURE;
                    end
                end else if (w_timeout) begin
                    w_err           = 1'b1;
                    w_match_cnt_nxt = '0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_match_cnt_nxt = '0;
                w_state_nxt     = IDLE;
            end
        endcase
        if (!i_en) begin
            w_state_nxt     = IDLE;
            w_match_cnt_nxt = '0;
            w_publish       = 1'b0;
            w_err           = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_match_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_per_cnt    <= '0;
            r_high_cnt   <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_rise       <= 1'b0;
            r_period_vld <= 1'b0;
            r_err        <= 1'b0;
        end else if (!i_en) begin
            // Published measurements are kept for software to read back.
            r_per_cnt    <= '0;
            r_high_cnt   <= '0;
            r_rise       <= 1'b0;
            r_period_vld <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rise       <= w_rise;
            r_period_vld <= w_publish;
            r_err        <= w_err;
            if (w_rise) begin
                r_per_cnt <= CNT_W'(1);
            end else if (r_per_cnt != c_cnt_max) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end
            if (w_rise) begin
                r_high_cnt <= CNT_W'(1);
            end else if (i_div_clk && (r_high_cnt != c_cnt_max)) begin
                r_high_cnt <= r_high_cnt + CNT_W'(1);
            end
            if (w_publish) begin
                r_period <= r_per_cnt;
                r_high   <= r_high_cnt;
            end
        end
    end

    // Counts the registered error pulse, so a clear raised in the same cycle
    // as a visible o_err leaves exactly that one error counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (i_err_clr) begin
            r_err_cnt <= {{(c_err_cnt_w-1){1'b0}}, r_err};
        end else if (r_err && (r_err_cnt != c_err_cnt_max)) begin
            r_err_cnt <= r_err_cnt + c_err_cnt_w'(1);
        end
    end

    assign o_rise       = r_rise;
    assign o_period     = r_period;
    assign o_high       = r_high;
    assign o_period_vld = r_period_vld;
    assign o_locked     = (r_state == LOCKED);
    assign o_err        = r_err;
    assign o_err_cnt    = r_err_cnt;

endmodule : div_clk_monitor
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_clk_monitor
// Description : Self-checking bench for div_clk_monitor. Expected publications
//               are queued as the waveform is driven and compared whenever
//               o_period_vld is seen; directed checks cover reset, timeout,
//               error counter clear/saturation, disable and duty behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_clk_monitor;

    localparam int c_timeout = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_en;
    logic       i_div_clk;
    logic       i_err_clr;
    logic       o_rise;
    logic [7:0] o_period;
    logic [7:0] o_high;
    logic       o_period_vld;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;

    int checks        = 0;
    int errors        = 0;
    int cyc           = 0;
    int last_rise_cyc = 0;
    int n_err         = 0;
    int n_err_snap    = 0;

    typedef struct {
        int period;
        int high;
        bit locked;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_clk_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .i_en         (i_en),
        .i_div_clk    (i_div_clk),
        .i_err_clr    (i_err_clr),
        .o_rise       (o_rise),
        .o_period     (o_period),
        .o_high       (o_high),
        .o_period_vld (o_period_vld),
        .o_locked     (o_locked),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_pub(input int p, input int h, input bit lk, input bit er);
        exp_t e;
        e.period = p;
        e.high   = h;
        e.locked = lk;
        e.err    = er;
        exp_q.push_back(e);
    endtask

    // One waveform period: h cycles high then l cycles low.
    task automatic drive_period(input int h, input int l);
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            i_div_clk = 1'b1;
        end
        for (int i = 0; i < l; i++) begin
            @(negedge clk);
            i_div_clk = 1'b0;
        end
    endtask

    // Waits (bounded) for the timeout error while the waveform stays low.
    task automatic wait_timeout(input bit clr);
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (o_err) found = 1'b1;
        end
        check("timeout_seen", found, 1);
        if (found) begin
            check("timeout_delay", cyc - last_rise_cyc, c_timeout);
            check("timeout_unlock", o_locked, 0);
            check("timeout_no_vld", o_period_vld, 0);
            if (clr) begin
                check("err_cnt_before_clr", o_err_cnt, 5);
                i_err_clr = 1'b1;
            end
            @(negedge clk);
            i_err_clr = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_rise"}, o_rise, 0);
        check({phase, "_period"}, o_period, 0);
        check({phase, "_high"}, o_high, 0);
        check({phase, "_vld"}, o_period_vld, 0);
        check({phase, "_locked"}, o_locked, 0);
        check({phase, "_err"}, o_err, 0);
        check({phase, "_err_cnt"}, o_err_cnt, 0);
    endtask

    // Scoreboard side: every publication must match the head of the queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (o_rise) last_rise_cyc = cyc;
        if (o_err) n_err++;
        if (o_period_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vld", o_period_vld, 0);
            end else begin
                e = exp_q.pop_front();
                check("pub_period", o_period, e.period);
                check("pub_high", o_high, e.high);
                check("pub_locked", o_locked, e.locked);
                check("pub_err", o_err, e.err);
                check("pub_rise", o_rise, 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        i_en      = 1'b0;
        i_div_clk = 1'b0;
        i_err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        i_en  = 1'b1;

        // Divide-by-3 lock: first edge silent, lock on the 5th rise.
        drive_period(1, 2);
        for (int r = 2; r <= 5; r++) begin
            expect_pub(3, 1, r == 5, 0);
            drive_period(1, 2);
        end
        check("locked_after_5", o_locked, 1);
        check("err_cnt_lock", o_err_cnt, 0);

        // Stretched period while locked, then relock after four matches.
        expect_pub(3, 1, 1, 0);
        drive_period(1, 3);
        expect_pub(4, 1, 0, 1);
        drive_period(1, 2);
        check("unlock_after_stretch", o_locked, 0);
        check("err_cnt_stretch", o_err_cnt, 1);
        for (int r = 1; r <= 4; r++) begin
            expect_pub(3, 1, r == 4, 0);
            drive_period(1, 2);
        end
        check("relock", o_locked, 1);
        check("err_cnt_relock", o_err_cnt, 1);

        // Asynchronous reset in the middle of a locked cycle.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        drive_period(1, 2);
        for (int r = 1; r <= 4; r++) begin
            expect_pub(3, 1, r == 4, 0);
            drive_period(1, 2);
        end
        check("relock_after_reset", o_locked, 1);

        // Loss of edges while locked.
        wait_timeout(1'b0);
        check("err_cnt_timeout", o_err_cnt, 1);
        for (int k = 0; k < 4; k++) begin
            drive_period(1, 2);
            wait_timeout(1'b0);
        end
        check("err_cnt_five", o_err_cnt, 5);

        // Clear coincident with an error pulse leaves one error counted.
        drive_period(1, 2);
        wait_timeout(1'b1);
        check("err_cnt_clr_coincide", o_err_cnt, 1);

        // Saturation.
        for (int k = 0; k < 260; k++) begin
            drive_period(1, 2);
            wait_timeout(1'b0);
        end
        @(negedge clk);
        check("err_cnt_saturated", o_err_cnt, 255);

        // Disabled: values hold, nothing pulses, no errors raised.
        @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        check("dis_locked", o_locked, 0);
        check("dis_period_hold", o_period, 3);
        check("dis_high_hold", o_high, 1);
        n_err_snap = n_err;
        drive_period(1, 2);
        drive_period(1, 2);
        repeat (c_timeout + 4) @(negedge clk);
        check("dis_no_err", n_err, n_err_snap);
        check("dis_err_cnt_hold", o_err_cnt, 255);
        check("dis_rise", o_rise, 0);

        // High time 2, period 3.
        @(negedge clk);
        i_en = 1'b1;
        drive_period(2, 1);
        for (int r = 2; r <= 7; r++) begin
`ifdef DIV_MON_DUTY_CHECK_EN
            expect_pub(3, 2, 0, 0);
`else
            expect_pub(3, 2, r >= 5, 0);
`endif
            drive_period(2, 1);
        end
        repeat (2) @(negedge clk);
        check("duty_no_err", n_err, n_err_snap);
        check("duty_err_cnt", o_err_cnt, 255);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_div_clk_monitor
`default_nettype wire
